led_frame_sequencer: RTL and testbench

- Upstream feeder for the LED strip driver. Holds a host-writable shadow pixel buffer and, on commit, copies it into the stable active frame.
- Presents the active frame to the driver on `rgb` and issues `load`, then waits for the driver's `done` pulse.
- Enforces the WS2812 latch/reset gap before the next frame can start. After reset it emits one blank priming frame so the driver's internal shift register is initialised.

---
 rtl/led_frame_sequencer_if.sv | 26 ++
 rtl/led_frame_sequencer.sv | 138 +++++++++++++
 tb/tb_led_frame_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_frame_sequencer_if.sv
// Host pixel-write/commit port and LED driver handshake for led_frame_sequencer.
// The sequencer takes the slave modport; the host/driver side takes master.
interface led_frame_sequencer_if #(
    parameter int unsigned NumPixels = 6
);
    logic                      wr_en;
    logic [2:0]                wr_addr;
    logic [23:0]               wr_data;
    logic                      commit;
    logic                      done;
    logic [24*NumPixels-1:0]   rgb;
    logic                      load;
    logic                      busy;
    logic [15:0]               frame_count;
    logic [1:0]                err;

    modport master (
        output wr_en, wr_addr, wr_data, commit, done,
        input  rgb, load, busy, frame_count, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, done,
        output rgb, load, busy, frame_count, err
    );
endinterface

// File: rtl/led_frame_sequencer.sv
// Shadow/active frame buffer feeding an LED strip driver: load handshake, done wait
// with timeout, latch gap, and one blank priming frame after reset.
module led_frame_sequencer #(
    parameter int unsigned NumPixels   = 6,
    parameter int unsigned LoadCycles  = 2,
    parameter int unsigned ResetCycles = 1500,
    parameter int unsigned DoneTimeout = 8192
) (
    input logic                  clk,
    input logic                  rst,
    led_frame_sequencer_if.slave bus_io
);
    localparam int unsigned FrameW    = 24 * NumPixels;
    localparam logic [15:0] LoadLast  = 16'(LoadCycles - 1);
    localparam logic [15:0] LatchLast = 16'(ResetCycles - 1);
    localparam logic [15:0] WaitLast  = 16'(DoneTimeout - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StWait, StLatch} state_e;

    state_e              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                prime_q, prime_d;
    logic                pending_q, pending_d;
    logic [23:0]         shadow_q [NumPixels];
    logic [23:0]         shadow_d [NumPixels];
    logic [FrameW-1:0]   shadow_flat;
    logic [FrameW-1:0]   rgb_q, rgb_d;
    logic [15:0]         frame_count_q, frame_count_d;
    logic [1:0]          err_q, err_d;
    logic                addr_ok;
    logic                copy;

    assign addr_ok = 32'(bus_io.wr_addr) < NumPixels;

    always_comb begin
        shadow_d = shadow_q;
        if (bus_io.wr_en && addr_ok) begin
            shadow_d[bus_io.wr_addr] = bus_io.wr_data;
        end
    end

    // Pixel 0 occupies the top slice because it is shifted out first.
    always_comb begin
        shadow_flat = '0;
        for (int unsigned k = 0; k < NumPixels; k++) begin
            shadow_flat[FrameW-1-24*k -: 24] = shadow_q[k];
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        prime_d       = prime_q;
        pending_d     = pending_q | bus_io.commit;
        rgb_d         = rgb_q;
        frame_count_d = frame_count_q;
        err_d         = err_q;
        copy          = 1'b0;

        if (bus_io.wr_en && !addr_ok) begin
            err_d[1] = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                copy = pending_q;
            end
            StLoad: begin
                if (cnt_q == LoadLast) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWait: begin
                // A done arriving on the timeout cycle still counts as a clean frame.
                if (bus_io.done) begin
                    if (!prime_q) frame_count_d = frame_count_q + 16'd1;
                    prime_d = 1'b0;
                    cnt_d   = '0;
                    state_d = StLatch;
                end else if (cnt_q == WaitLast) begin
                    err_d[0] = 1'b1;
                    prime_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = StLatch;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StLatch: begin
                if (cnt_q == LatchLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    copy    = pending_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase

        if (copy) begin
            rgb_d     = shadow_flat;
            pending_d = bus_io.commit;
            cnt_d     = '0;
            state_d   = StLoad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StLoad;
            cnt_q         <= '0;
            prime_q       <= 1'b1;
            pending_q     <= 1'b0;
            for (int unsigned k = 0; k < NumPixels; k++) shadow_q[k] <= '0;
            rgb_q         <= '0;
            frame_count_q <= '0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prime_q       <= prime_d;
            pending_q     <= pending_d;
            shadow_q      <= shadow_d;
            rgb_q         <= rgb_d;
            frame_count_q <= frame_count_d;
            err_q         <= err_d;
        end
    end

    assign bus_io.rgb         = rgb_q;
    assign bus_io.load        = (state_q == StLoad);
    assign bus_io.busy        = (state_q != StIdle);
    assign bus_io.frame_count = frame_count_q;
    assign bus_io.err         = err_q;
endmodule

// File: tb/tb_led_frame_sequencer.sv
// Randomised scoreboard bench for led_frame_sequencer: stimulus pushes expected frames,
// a monitor pops them on each load rise, and a driver model answers with done.
module tb_led_frame_sequencer;
    localparam int unsigned NP = 6;
    localparam int unsigned LC = 2;
    localparam int unsigned RC = 1500;
    localparam int unsigned TO = 8192;
    localparam int unsigned W  = 24 * NP;

    typedef struct {
        logic [W-1:0] rgb;
        bit           prime;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led_frame_sequencer_if #(.NumPixels(NP)) bus ();

    led_frame_sequencer #(
        .NumPixels  (NP),
        .LoadCycles (LC),
        .ResetCycles(RC),
        .DoneTimeout(TO)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    int          checks = 0;
    int          failures = 0;
    frame_t      exp_q[$];
    logic [23:0] sh [NP];
    logic [15:0] m_fc = '0;
    logic [1:0]  m_err = '0;
    bit          outstanding = 0;
    bit          hang = 0;
    bit          mon_en = 0;
    bit          cur_prime = 1;
    int          rise_cnt = 0;
    int          done_cnt = 0;
    int unsigned rise_cyc = 0;
    int unsigned done_cyc = 0;
    logic [W-1:0] last_exp_rgb = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expired(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    function automatic logic [W-1:0] pack_frame();
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < int'(NP); k++) v[W-1-24*k -: 24] = sh[k];
        return v;
    endfunction

    // Monitor: samples 1 time unit after each active edge.
    initial begin : monitor
        logic   prev_load;
        int     len;
        frame_t f;
        logic [W-1:0] seen_rgb;
        prev_load = 1'b0;
        len = 0;
        seen_rgb = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!mon_en) begin
                prev_load = 1'b0;
                continue;
            end
            if (bus.load && !prev_load) begin
                rise_cnt++;
                rise_cyc = cyc;
                len = 1;
                if (exp_q.size() == 0) begin
                    expired("unexpected_frame");
                end else begin
                    f = exp_q.pop_front();
                    chk("frame_rgb", bus.rgb, f.rgb);
                    chk("frame_count_at_load", W'(bus.frame_count), W'(m_fc));
                    chk("err_at_load", W'(bus.err), W'(m_err));
                    cur_prime = f.prime;
                    last_exp_rgb = f.rgb;
                    if (!f.prime) outstanding = 0;
                end
                seen_rgb = bus.rgb;
            end else begin
                if (bus.load) len++;
                if (!bus.load && prev_load) chk("load_width", W'(len), W'(LC));
                chk("rgb_stable", bus.rgb, seen_rgb);
            end
            prev_load = bus.load;
        end
    end

    // Driver model: pulses done some cycles after each frame start unless hung.
    initial begin : driver
        int seen;
        int lat;
        seen = 0;
        bus.done = 1'b0;
        forever begin
            @(negedge clk);
            if (rise_cnt != seen) begin
                seen = rise_cnt;
                if (!hang) begin
                    lat = cur_prime ? 4400 : int'($urandom_range(40, 300));
                    repeat (lat - 1) @(negedge clk);
                    bus.done = 1'b1;
                    done_cyc = cyc;
                    if (!cur_prime) m_fc = m_fc + 16'd1;
                    done_cnt++;
                    @(negedge clk);
                    bus.done = 1'b0;
                end
            end
        end
    end

    task automatic model_write(input logic [2:0] a, input logic [23:0] d);
        if (int'(a) < int'(NP)) sh[a] = d;
        else m_err[1] = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [23:0] d);
        bus.wr_en = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        model_write(a, d);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    // Optional write in the same cycle belongs to the committed frame.
    task automatic do_commit(input bit with_wr, input logic [2:0] a, input logic [23:0] d);
        if (with_wr) begin
            bus.wr_en = 1'b1;
            bus.wr_addr = a;
            bus.wr_data = d;
            model_write(a, d);
        end
        if (!outstanding) exp_q.push_back('{rgb: pack_frame(), prime: 1'b0});
        outstanding = 1;
        bus.commit = 1'b1;
        @(negedge clk);
        bus.commit = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_rise(input int target);
        int n = 0;
        while (rise_cnt < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (rise_cnt < target) expired("wait_frame_start");
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) expired("wait_done");
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((bus.busy || outstanding) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy || outstanding) expired("wait_idle");
    endtask

    task automatic wait_free();
        int n = 0;
        while (outstanding && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (outstanding) expired("wait_commit_served");
    endtask

    initial begin : main
        int unsigned c;
        int unsigned d;
        int unsigned r;
        int          r0;
        int          d0;
        logic [15:0] fc0;
        logic [W-1:0] t2;
        logic [2:0]  a;

        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.commit = 1'b0;
        for (int k = 0; k < int'(NP); k++) sh[k] = '0;

        // Power-on reset, priming frame of zeros.
        @(negedge clk);
        exp_q.push_back('{rgb: '0, prime: 1'b1});
        mon_en = 1;
        @(negedge clk);
        rst = 1'b0;
        wait_done(1);
        d = done_cyc;
        wait_cyc(d + RC);
        chk("busy_in_latch", W'(bus.busy), W'(1));
        wait_cyc(d + RC + 1);
        chk("busy_after_latch", W'(bus.busy), W'(0));
        chk("prime_not_counted", W'(bus.frame_count), W'(0));

        // Two-pixel frame and exact commit-to-load latency.
        wr(3'd0, 24'hFF0000);
        wr(3'd5, 24'h0000FF);
        c = cyc;
        do_commit(0, 3'd0, 24'd0);
        wait_cyc(c + 1);
        chk("load_not_yet", W'(bus.load), W'(0));
        wait_cyc(c + 2);
        t2 = 144'hFF0000_000000_000000_000000_000000_0000FF;
        chk("load_after_commit", W'(bus.load), W'(1));
        chk("rgb_after_commit", bus.rgb, t2);
        wait_idle();
        chk("frame_count_one", W'(bus.frame_count), W'(1));

        // Three commits during WAIT merge into one back-to-back frame.
        fc0 = m_fc;
        r0 = rise_cnt;
        d0 = done_cnt;
        wr(3'd2, 24'h00AA00);
        do_commit(0, 3'd0, 24'd0);
        wait_rise(r0 + 1);
        wr(3'd3, 24'h112233);
        for (int i = 0; i < 3; i++) do_commit(0, 3'd0, 24'd0);
        wait_done(d0 + 1);
        d = done_cyc;
        wait_rise(r0 + 2);
        chk("back_to_back_gap", W'(rise_cyc - d), W'(RC + 1));
        wait_idle();
        chk("merged_frame_starts", W'(rise_cnt - r0), W'(2));
        chk("merged_frame_count", W'(bus.frame_count), W'(fc0 + 16'd2));

        // Out-of-range write is dropped and flagged.
        wr(3'd6, 24'h123456);
        chk("oob_err", W'(bus.err), W'(2'b10));
        chk("oob_rgb_unchanged", bus.rgb, last_exp_rgb);
        wr(3'd7, 24'hABCDEF);
        do_commit(0, 3'd0, 24'd0);
        wait_idle();

        // Driver never answers: timeout, latch, back to idle.
        hang = 1;
        fc0 = m_fc;
        r0 = rise_cnt;
        do_commit(0, 3'd0, 24'd0);
        wait_rise(r0 + 1);
        r = rise_cyc;
        wait_cyc(r + LC + TO - 1);
        chk("no_timeout_yet", W'(bus.err), W'(m_err));
        wait_cyc(r + LC + TO);
        m_err[0] = 1'b1;
        chk("timeout_err", W'(bus.err), W'(m_err));
        wait_cyc(r + LC + TO + RC - 1);
        chk("timeout_latch_busy", W'(bus.busy), W'(1));
        wait_cyc(r + LC + TO + RC);
        chk("timeout_idle", W'(bus.busy), W'(0));
        chk("timeout_frame_count", W'(bus.frame_count), W'(fc0));
        hang = 0;
        wr(3'd1, 24'h0F0F0F);
        do_commit(0, 3'd0, 24'd0);
        wait_idle();
        chk("after_timeout_count", W'(bus.frame_count), W'(fc0 + 16'd1));

        // Randomised writes, commits and merged commits.
        for (int it = 0; it < 6; it++) begin
            wait_free();
            for (int k = 0; k < int'($urandom_range(0, 4)); k++) begin
                a = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1))
                                                : 3'($urandom_range(0, NP - 1));
                wr(a, 24'($urandom));
            end
            r0 = rise_cnt;
            if ($urandom_range(0, 1) == 1) do_commit(1, 3'($urandom_range(0, NP - 1)),
                                                     24'($urandom));
            else do_commit(0, 3'd0, 24'd0);
            if ($urandom_range(0, 1) == 1) begin
                wait_rise(r0 + 1);
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) do_commit(0, 3'd0, 24'd0);
            end
        end
        wait_idle();
        chk("random_frame_count", W'(bus.frame_count), W'(m_fc));
        chk("random_err", W'(bus.err), W'(m_err));

        // Reset in the middle of WAIT restarts with a priming frame.
        hang = 1;
        r0 = rise_cnt;
        do_commit(0, 3'd0, 24'd0);
        wait_rise(r0 + 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < int'(NP); k++) sh[k] = '0;
        m_fc = '0;
        m_err = '0;
        outstanding = 0;
        exp_q.push_back('{rgb: '0, prime: 1'b1});
        hang = 0;
        d0 = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_load", W'(bus.load), W'(1));
        chk("reset_rgb", bus.rgb, W'(0));
        chk("reset_frame_count", W'(bus.frame_count), W'(0));
        chk("reset_err", W'(bus.err), W'(0));
        wait_done(d0 + 1);
        wait_idle();
        chk("reprime_count", W'(bus.frame_count), W'(0));
        wr(3'd4, 24'h00FF00);
        do_commit(1, 3'd2, 24'h808080);
        wait_idle();
        chk("final_count", W'(bus.frame_count), W'(1));
        chk("scoreboard_empty", W'(exp_q.size()), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
